// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// One operation is in flight at a time: IDLE accepts, EXEC captures the ALU
// result, RESP presents it until the consumer takes it.
module alu_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic        req1_valid,
   output logic        req0_ready,
   output logic        req1_ready,
   input  logic [3:0]  req0_ctrl,
   input  logic [3:0]  req1_ctrl,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_data,
   output logic        rsp_zero,
   output logic [31:0] alu_in1,
   output logic [31:0] alu_in2,
   output logic [3:0]  alu_ctrl,
   input  logic [31:0] alu_out,
   input  logic        alu_zero,
   output logic        busy
);

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StExec = 2'b01,
      StResp = 2'b10
   } state_e;

   state_e      r_state;
   state_e      w_state_nxt;

   logic        r_last;      // requester granted most recently
   logic        r_owner;     // requester owning the in-flight operation
   logic [3:0]  r_alu_ctrl;
   logic [31:0] r_alu_in1;
   logic [31:0] r_alu_in2;
   logic [31:0] r_rsp_data;
   logic        r_rsp_zero;
   logic        r_rsp_id;

   logic        w_gnt_any;
   logic        w_gnt_id;

   // Grant selection: a lone requester wins, contention goes to the one not served last.
   always_comb begin
      w_gnt_any = 1'b0;
      w_gnt_id  = 1'b0;
      if (r_state == StIdle) begin
         w_gnt_any = req0_valid | req1_valid;
         if (req0_valid && req1_valid) begin
            w_gnt_id = ~r_last;
         end else begin
            w_gnt_id = req1_valid;
         end
      end
   end

   // Next-state logic; the spare encoding falls back to IDLE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StIdle:  if (w_gnt_any) w_state_nxt = StExec;
         StExec:  w_state_nxt = StResp;
         StResp:  if (rsp_ready) w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Latch the granted operation into the ALU drive registers on a request handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_ctrl <= 4'b0000;
         r_alu_in1  <= 32'h0;
         r_alu_in2  <= 32'h0;
         r_owner    <= 1'b0;
         r_last     <= 1'b1;  // req0 wins the first contention after reset
      end else if (w_gnt_any) begin
         r_alu_ctrl <= w_gnt_id ? req1_ctrl : req0_ctrl;
         r_alu_in1  <= w_gnt_id ? req1_a : req0_a;
         r_alu_in2  <= w_gnt_id ? req1_b : req0_b;
         r_owner    <= w_gnt_id;
         r_last     <= w_gnt_id;
      end
   end

   // Capture the ALU result during EXEC; held through RESP until taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_data <= 32'h0;
         r_rsp_zero <= 1'b0;
         r_rsp_id   <= 1'b0;
      end else if (r_state == StExec) begin
         r_rsp_data <= alu_out;
         r_rsp_zero <= alu_zero;
         r_rsp_id   <= r_owner;
      end
   end

   assign req0_ready = w_gnt_any & ~w_gnt_id;
   assign req1_ready = w_gnt_any & w_gnt_id;
   assign rsp_valid  = (r_state == StResp);
   assign busy       = (r_state != StIdle);
   assign rsp_data   = r_rsp_data;
   assign rsp_zero   = r_rsp_zero;
   assign rsp_id     = r_rsp_id;
   assign alu_ctrl   = r_alu_ctrl;
   assign alu_in1    = r_alu_in1;
   assign alu_in2    = r_alu_in2;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of the arbiter and a behavioural ALU.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [3:0]  req0_ctrl = '0, req1_ctrl = '0;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic        rsp_valid, rsp_ready = 1'b0;
   logic        rsp_id, rsp_zero;
   logic [31:0] rsp_data;
   logic [31:0] alu_in1, alu_in2;
   logic [3:0]  alu_ctrl;
   logic [31:0] alu_out;
   logic        alu_zero;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req1_valid (req1_valid),
      .req0_ready (req0_ready),
      .req1_ready (req1_ready),
      .req0_ctrl  (req0_ctrl),
      .req1_ctrl  (req1_ctrl),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .rsp_zero   (rsp_zero),
      .alu_in1    (alu_in1),
      .alu_in2    (alu_in2),
      .alu_ctrl   (alu_ctrl),
      .alu_out    (alu_out),
      .alu_zero   (alu_zero),
      .busy       (busy)
   );

   // Behavioural shared ALU; unused opcodes return an arbitrary but deterministic mix.
   function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
      case (c)
         4'b0110: return a + b;
         4'b0001: return a - b;
         4'b0111: return a ^ b;
         4'b1000: return a | b;
         4'b1001: return a & b;
         4'b1010: return a << b[4:0];
         4'b1011: return a >> b[4:0];
         4'b1100: return $unsigned($signed(a) >>> b[4:0]);
         default: return {a[15:0], b[15:0]} ^ {28'h0, c};
      endcase
   endfunction

   assign alu_out  = ref_alu(alu_ctrl, alu_in1, alu_in2);
   assign alu_zero = (alu_out == 32'h0);

   // Reset, then release just after a rising edge so the next edge is the first usable one.
   task automatic apply_reset();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b0;
      rst_n      = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst_n      = 1'b0;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
      checks++; if (rsp_data !== 32'h0 || rsp_id !== 1'b0 || rsp_zero !== 1'b0) begin
         errors++; $display("FAIL reset_rsp: got data=%0h id=%0b zero=%0b want 0/0/0", rsp_data, rsp_id, rsp_zero); end
      checks++; if (alu_in1 !== 32'h0 || alu_in2 !== 32'h0 || alu_ctrl !== 4'h0) begin
         errors++; $display("FAIL reset_alu: got %0h %0h %0h want 0 0 0", alu_in1, alu_in2, alu_ctrl); end
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
         errors++; $display("FAIL reset_ready: got %0b%0b want 00", req0_ready, req1_ready); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      // A grant must be possible on the very first edge after release.
      req0_valid = 1'b1; req0_ctrl = 4'b1001; req0_a = 32'hF0F0_1234; req0_b = 32'h0FF0_FFFF;
      rsp_ready  = 1'b1;
      @(negedge clk);
      checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL first_grant_ready: got %0b want 1", req0_ready); end
      @(posedge clk);
      #1 req0_valid = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b1 || alu_ctrl !== 4'b1001) begin
         errors++; $display("FAIL first_grant_exec: got busy=%0b ctrl=%0h want 1/9", busy, alu_ctrl); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (rsp_data !== 32'h00F0_1234) begin
         errors++; $display("FAIL first_grant_and: got %0h want 00f01234", rsp_data); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic_add();
      req0_valid = 1'b1; req0_ctrl = 4'b0110; req0_a = 32'd5; req0_b = 32'd7;
      rsp_ready  = 1'b1;
      @(negedge clk);
      checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         errors++; $display("FAIL add_ready: got %0b%0b want 10", req0_ready, req1_ready); end
      @(posedge clk);  // request handshake, edge N
      #1 req0_valid = 1'b0;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL add_exec: got valid=%0b busy=%0b want 0/1", rsp_valid, busy); end
      checks++; if (alu_in1 !== 32'd5 || alu_in2 !== 32'd7 || alu_ctrl !== 4'b0110) begin
         errors++; $display("FAIL add_drive: got %0h %0h %0h want 5 7 6", alu_in1, alu_in2, alu_ctrl); end
      @(posedge clk);  // edge N+1; response is taken at edge N+2
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd12 || rsp_id !== 1'b0 || rsp_zero !== 1'b0) begin
         errors++; $display("FAIL add_rsp: got v=%0b d=%0h id=%0b z=%0b want 1/c/0/0", rsp_valid, rsp_data, rsp_id, rsp_zero); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL add_done: got valid=%0b busy=%0b want 0/0", rsp_valid, busy); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_contention();
      logic exp_id;
      apply_reset();
      req0_valid = 1'b1; req0_ctrl = 4'b0001; req0_a = 32'd3;    req0_b = 32'd3;
      req1_valid = 1'b1; req1_ctrl = 4'b1000; req1_a = 32'hF0;  req1_b = 32'h0F;
      rsp_ready  = 1'b1;
      for (int k = 0; k < 8; k++) begin
         exp_id = k[0];  // req0 first after reset, then strict alternation
         @(negedge clk);
         checks++; if (req0_ready !== !exp_id || req1_ready !== exp_id) begin
            errors++; $display("FAIL rr_grant[%0d]: got %0b%0b want id %0b", k, req0_ready, req1_ready, exp_id); end
         @(posedge clk);
         @(negedge clk);
         checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL rr_busy_ready[%0d]: got %0b%0b want 00", k, req0_ready, req1_ready); end
         @(posedge clk);
         @(negedge clk);
         checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id ||
                       rsp_data !== (exp_id ? 32'hFF : 32'h0) || rsp_zero !== !exp_id) begin
            errors++; $display("FAIL rr_rsp[%0d]: got v=%0b id=%0b d=%0h z=%0b want id %0b", k,
                               rsp_valid, rsp_id, rsp_data, rsp_zero, exp_id); end
         @(posedge clk);
      end
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      req0_valid = 1'b1; req0_ctrl = 4'b0111; req0_a = a; req0_b = b;
      rsp_ready  = 1'b0;
      @(posedge clk);
      #1 req0_valid = 1'b0;
      req1_valid = 1'b1; req1_ctrl = 4'b0110; req1_a = 32'd1; req1_b = 32'd1;
      @(posedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++; if (rsp_valid !== 1'b1 || rsp_data !== (a ^ b) || rsp_id !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL bp_hold[%0d]: got v=%0b d=%0h id=%0b busy=%0b want 1/%0h/0/1", k,
                               rsp_valid, rsp_data, rsp_id, busy, a ^ b); end
         checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL bp_ready[%0d]: got %0b%0b want 00", k, req0_ready, req1_ready); end
         checks++; if (alu_in1 !== a || alu_in2 !== b || alu_ctrl !== 4'b0111) begin
            errors++; $display("FAIL bp_drive[%0d]: got %0h %0h %0h want %0h %0h 7", k, alu_in1, alu_in2,
                               alu_ctrl, a, b); end
         @(posedge clk);
      end
      #1 rsp_ready = 1'b1;
      req1_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %0b want 0", rsp_valid); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_in_exec();
      req1_valid = 1'b1; req1_ctrl = 4'b0111; req1_a = 32'hAAAA_5555; req1_b = 32'hFFFF_0000;
      rsp_ready  = 1'b1;
      @(posedge clk);
      #1 req1_valid = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_exec_busy: got %0b want 1", busy); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_id !== 1'b0 || rsp_zero !== 1'b0) begin
         errors++; $display("FAIL rst_exec_ctl: got v=%0b busy=%0b id=%0b z=%0b want 0000", rsp_valid, busy,
                            rsp_id, rsp_zero); end
      checks++; if (rsp_data !== 32'h0 || alu_in1 !== 32'h0 || alu_in2 !== 32'h0 || alu_ctrl !== 4'h0) begin
         errors++; $display("FAIL rst_exec_data: got %0h %0h %0h %0h want all 0", rsp_data, alu_in1,
                            alu_in2, alu_ctrl); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         @(negedge clk);
         checks++; if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_exec_no_rsp[%0d]: got v=%0b id=%0b want v=0", k, rsp_valid, rsp_id); end
      end
      // Last-granted was reset to 1, so req0 wins; both withdraw before the edge.
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         errors++; $display("FAIL rst_exec_rr: got %0b%0b want 10", req0_ready, req1_ready); end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL withdraw_no_grant: got busy=%0b want 0", busy); end
   endtask

   task automatic test_sra_and_unused();
      logic [31:0] exp;
      rsp_ready  = 1'b1;
      req1_valid = 1'b1; req1_ctrl = 4'b1100; req1_a = 32'h8000_0000; req1_b = 32'd4;
      @(posedge clk);
      #1 req1_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++; if (rsp_data !== 32'hF800_0000 || rsp_id !== 1'b1 || rsp_zero !== 1'b0) begin
         errors++; $display("FAIL sra_rsp: got d=%0h id=%0b z=%0b want f8000000/1/0", rsp_data, rsp_id, rsp_zero); end
      @(posedge clk);
      #1;
      req0_valid = 1'b1; req0_ctrl = 4'b1110; req0_a = 32'h1234_5678; req0_b = 32'h9ABC_DEF0;
      exp = ref_alu(4'b1110, 32'h1234_5678, 32'h9ABC_DEF0);
      @(negedge clk);
      checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL op1110_ready: got %0b want 1", req0_ready); end
      @(posedge clk);
      #1 req0_valid = 1'b0;
      checks++; if (alu_ctrl !== 4'b1110) begin errors++; $display("FAIL op1110_ctrl: got %0h want e", alu_ctrl); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp || rsp_id !== 1'b0) begin
         errors++; $display("FAIL op1110_rsp: got v=%0b d=%0h id=%0b want 1/%0h/0", rsp_valid, rsp_data, rsp_id, exp); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL op1110_done: got v=%0b busy=%0b want 0/0", rsp_valid, busy); end
      @(posedge clk);
      #1;
   endtask

   // Transaction-level model: one operation outstanding, result due two edges after
   // acceptance, round-robin on contention.
   task automatic test_random();
      int          phase;     // 0 free, 1 result being computed, 2 result offered
      logic        m_last;
      logic        p_id;
      logic [3:0]  p_ctrl;
      logic [31:0] p_a, p_b, p_res;
      logic        g_any, g_id;
      int          wait0, wait1;
      apply_reset();
      phase = 0; m_last = 1'b1; p_id = 1'b0; p_ctrl = '0; p_a = '0; p_b = '0;
      wait0 = 0; wait1 = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         req0_valid = ($urandom_range(0, 2) != 0);
         req1_valid = ($urandom_range(0, 2) != 0);
         req0_ctrl  = 4'($urandom_range(0, 15));
         req1_ctrl  = 4'($urandom_range(0, 15));
         req0_a     = $urandom;
         req1_a     = $urandom;
         req0_b     = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
         req1_b     = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
         rsp_ready  = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         g_any = (phase == 0) && (req0_valid || req1_valid);
         g_id  = (req0_valid && req1_valid) ? !m_last : req1_valid;
         checks++; if (req0_ready !== (g_any && !g_id) || req1_ready !== (g_any && g_id)) begin
            errors++; $display("FAIL rnd_ready[%0d]: got %0b%0b want %0b%0b", cyc, req0_ready, req1_ready,
                               g_any && !g_id, g_any && g_id); end
         checks++; if (busy !== (phase != 0) || rsp_valid !== (phase == 2)) begin
            errors++; $display("FAIL rnd_status[%0d]: got busy=%0b v=%0b want phase %0d", cyc, busy, rsp_valid, phase); end
         if (phase != 0) begin
            checks++; if (alu_ctrl !== p_ctrl || alu_in1 !== p_a || alu_in2 !== p_b) begin
               errors++; $display("FAIL rnd_drive[%0d]: got %0h %0h %0h want %0h %0h %0h", cyc, alu_ctrl,
                                  alu_in1, alu_in2, p_ctrl, p_a, p_b); end
         end
         if (phase == 2) begin
            p_res = ref_alu(p_ctrl, p_a, p_b);
            checks++; if (rsp_data !== p_res || rsp_zero !== (p_res == 32'h0) || rsp_id !== p_id) begin
               errors++; $display("FAIL rnd_rsp[%0d]: got d=%0h z=%0b id=%0b want %0h/%0b/%0b", cyc, rsp_data,
                                  rsp_zero, rsp_id, p_res, p_res == 32'h0, p_id); end
         end
         // Starvation bound: count arbitration rounds a held request loses.
         if (g_any && req0_valid && req1_valid) begin
            if (g_id) wait0++; else wait1++;
            checks++; if (wait0 > 1 || wait1 > 1) begin
               errors++; $display("FAIL rnd_starve[%0d]: got losses %0d/%0d want <=1", cyc, wait0, wait1); end
         end
         if (g_any && !g_id) wait0 = 0;
         if (g_any && g_id) wait1 = 0;
         if (!req0_valid) wait0 = 0;
         if (!req1_valid) wait1 = 0;
         if (g_any) begin
            p_id   = g_id;
            p_ctrl = g_id ? req1_ctrl : req0_ctrl;
            p_a    = g_id ? req1_a : req0_a;
            p_b    = g_id ? req1_b : req0_b;
            m_last = g_id;
            phase  = 1;
         end else if (phase == 1) begin
            phase = 2;
         end else if (phase == 2 && rsp_ready) begin
            phase = 0;
         end
         @(posedge clk);
         #1;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      apply_reset();
      test_reset();
      test_basic_add();
      test_contention();
      test_backpressure();
      test_reset_in_exec();
      test_sra_and_unused();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
